instr_fetch_aligner: RTL and testbench

- Sits between the instruction fetch port and the RVC decompressor, and produces that decompressor's 32-bit `i_instr` input.
- Accepts word-aligned 32-bit fetch words that contain a mix of 16-bit and 32-bit instructions, including 32-bit instructions that straddle two words.
- Emits one instruction per handshake, right-aligned:
  - compressed instructions are zero-extended in bits [31:16];
  - 32-bit instructions are reassembled whole.
- Tracks the instruction PC and supports redirect (flush).

---
 rtl/instr_fetch_aligner.sv | 123 ++++++++++++
 tb/tb_instr_fetch_aligner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_aligner.sv
// instr_fetch_aligner: turns word-aligned 32-bit fetch words carrying a mix of
// 16-bit and 32-bit instructions into one right-aligned instruction per
// handshake. Straddling 32-bit instructions are reassembled from two words.
// Optional performance counters are built when FETCH_ALIGN_PERF_EN is defined.
module instr_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          HQ_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_data,
  output logic        o_fetch_ready,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_is_compr,
`ifdef FETCH_ALIGN_PERF_EN
  output logic [31:0] o_perf_compr_cnt,
  output logic [31:0] o_perf_full_cnt,
`endif
  input  logic        i_instr_ready
);

  localparam int CW = $clog2(HQ_DEPTH + 1);
  localparam int AW = $clog2(HQ_DEPTH);

  logic [15:0]   hq     [HQ_DEPTH];
  logic [15:0]   hq_n   [HQ_DEPTH];
  logic [CW-1:0] cnt;
  logic [31:0]   pc_q;
  logic          skip_lo;

  logic          compr;
  logic          do_pop;
  logic          do_push;
  logic [CW-1:0] pop_n;
  logic [CW-1:0] push_n;
  logic [CW-1:0] rem;
  logic [AW-1:0] wr_idx;
  logic [31:0]   pc_inc;

  // Head classification and presentation come straight from the registered
  // queue, so nothing on the fetch side reaches o_instr in the same cycle.
  assign compr         = (hq[0][1:0] != 2'b11);
  assign o_instr_valid = ((cnt >= CW'(1)) && compr) || (cnt >= CW'(2));
  assign o_instr       = compr ? {16'h0000, hq[0]} : {hq[1], hq[0]};
  assign o_is_compr    = compr;
  assign o_instr_pc    = pc_q;
  assign o_fetch_ready = (cnt <= CW'(2)) && !i_flush;

  assign do_pop  = o_instr_valid && i_instr_ready;
  assign do_push = i_fetch_valid && o_fetch_ready;
  assign pop_n   = do_pop  ? (compr   ? CW'(1) : CW'(2)) : CW'(0);
  assign push_n  = do_push ? (skip_lo ? CW'(1) : CW'(2)) : CW'(0);
  assign rem     = cnt - pop_n;
  assign wr_idx  = rem[AW-1:0];
  assign pc_inc  = {{(32-CW-1){1'b0}}, pop_n, 1'b0};

  // Next queue contents: shift out popped halfwords, then append the pushed
  // ones behind whatever remains. Pushes only land at or beyond cnt, so a
  // held instruction in hq[0]/hq[1] is never overwritten.
  always_comb begin
    // NOTE: every element gets a default first so no path leaves hq_n
    // unassigned, which would otherwise infer a latch.
    for (int i = 0; i < HQ_DEPTH; i++) hq_n[i] = hq[i];
    case (pop_n)
      CW'(1): for (int i = 0; i < HQ_DEPTH - 1; i++) hq_n[i] = hq[i+1];
      CW'(2): for (int i = 0; i < HQ_DEPTH - 2; i++) hq_n[i] = hq[i+2];
      default: ;
    endcase
    if (do_push) begin
      if (skip_lo) begin
        hq_n[wr_idx] = i_fetch_data[31:16];
      end else begin
        hq_n[wr_idx]         = i_fetch_data[15:0];
        hq_n[wr_idx + AW'(1)] = i_fetch_data[31:16];
      end
    end
  end

  // Halfword storage: pure data, qualified entirely by cnt.
  // NOTE: the queue array is deliberately left out of reset; cnt=0 marks
  // every entry invalid, so resetting the storage would buy nothing.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < HQ_DEPTH; i++) hq[i] <= hq_n[i];
  end

  // Occupancy, head PC and half-word skip; flush overrides any handshake.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      pc_q    <= RESET_PC;
      skip_lo <= RESET_PC[1];
    end else if (i_flush) begin
      cnt     <= '0;
      pc_q    <= i_flush_pc & ~32'h1;
      skip_lo <= i_flush_pc[1];
    end else begin
      cnt  <= cnt + push_n - pop_n;
      pc_q <= pc_q + pc_inc;
      if (do_push && skip_lo) skip_lo <= 1'b0;
    end
  end

`ifdef FETCH_ALIGN_PERF_EN
  // Retired-instruction counters by width; flush does not clear them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_compr_cnt <= '0;
      o_perf_full_cnt  <= '0;
    end else if (do_pop && !i_flush) begin
      if (compr) o_perf_compr_cnt <= o_perf_compr_cnt + 32'd1;
      else       o_perf_full_cnt  <= o_perf_full_cnt  + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_aligner.sv
// tb_instr_fetch_aligner: directed scenarios plus randomized traffic checked
// every cycle against a halfword-queue reference model.
module tb_instr_fetch_aligner;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_fetch_valid = 1'b0;
  logic [31:0] i_fetch_data = '0;
  logic        o_fetch_ready;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_pc = '0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_is_compr;
  logic        i_instr_ready = 1'b0;
`ifdef FETCH_ALIGN_PERF_EN
  logic [31:0] o_perf_compr_cnt;
  logic [31:0] o_perf_full_cnt;
`endif

  instr_fetch_aligner dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_fetch_valid(i_fetch_valid), .i_fetch_data(i_fetch_data),
    .o_fetch_ready(o_fetch_ready),
    .i_flush(i_flush), .i_flush_pc(i_flush_pc),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr),
    .o_instr_pc(o_instr_pc), .o_is_compr(o_is_compr),
`ifdef FETCH_ALIGN_PERF_EN
    .o_perf_compr_cnt(o_perf_compr_cnt), .o_perf_full_cnt(o_perf_full_cnt),
`endif
    .i_instr_ready(i_instr_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of halfwords plus head PC and skip flag.
  logic [15:0] mq[$];
  logic [31:0] mpc;
  bit          mskip;
  logic [31:0] m_compr_cnt, m_full_cnt;

  function automatic bit m_compr();
    return (mq.size() >= 1) && (mq[0][1:0] != 2'b11);
  endfunction
  function automatic bit m_valid();
    return m_compr() || (mq.size() >= 2);
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mq.delete();
      mpc = 32'h0;
      mskip = 1'b0;
      m_compr_cnt = 0;
      m_full_cnt = 0;
    end else if (i_flush) begin
      mq.delete();
      mpc = i_flush_pc & ~32'h1;
      mskip = i_flush_pc[1];
    end else begin
      bit acc;
      acc = i_fetch_valid && (mq.size() <= 2);
      if (m_valid() && i_instr_ready) begin
        if (m_compr()) begin
          void'(mq.pop_front()); mpc += 2; m_compr_cnt++;
        end else begin
          void'(mq.pop_front()); void'(mq.pop_front()); mpc += 4; m_full_cnt++;
        end
      end
      if (acc) begin
        if (!mskip) mq.push_back(i_fetch_data[15:0]);
        mq.push_back(i_fetch_data[31:16]);
        mskip = 1'b0;
      end
    end
  end

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; logic compr; } emit_t;
  emit_t log_q[$];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    bit ev;
    ev = m_valid();
    check("fetch_ready", {31'b0, o_fetch_ready}, {31'b0, (mq.size() <= 2) && !i_flush});
    check("instr_valid", {31'b0, o_instr_valid}, {31'b0, ev});
    check("instr_pc", o_instr_pc, mpc);
    if (mq.size() >= 1) check("is_compr", {31'b0, o_is_compr}, {31'b0, m_compr()});
    if (ev) check("instr", o_instr, m_compr() ? {16'h0, mq[0]} : {mq[1], mq[0]});
`ifdef FETCH_ALIGN_PERF_EN
    check("perf_compr", o_perf_compr_cnt, m_compr_cnt);
    check("perf_full", o_perf_full_cnt, m_full_cnt);
`endif
    if (i_rst_n && o_instr_valid && i_instr_ready && !i_flush)
      log_q.push_back('{o_instr, o_instr_pc, o_is_compr});
  end

  // Drive one cycle of inputs, held until just after the next rising edge.
  task automatic drive(input logic fv, input logic [31:0] fd, input logic ir,
                       input logic fl, input logic [31:0] fp);
    i_fetch_valid = fv; i_fetch_data = fd; i_instr_ready = ir;
    i_flush = fl; i_flush_pc = fp;
    @(posedge i_clk); #1;
  endtask

  // Offer a word until it is accepted, within a bounded number of cycles.
  task automatic push_word(input logic [31:0] fd, input logic ir);
    bit acc = 0;
    for (int n = 0; n < 20 && !acc; n++) begin
      i_fetch_valid = 1'b1; i_fetch_data = fd; i_instr_ready = ir; i_flush = 1'b0;
      @(negedge i_clk);
      acc = o_fetch_ready;
      @(posedge i_clk); #1;
    end
    i_fetch_valid = 1'b0;
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic ir);
    repeat (n) drive(1'b0, 32'h0, ir, 1'b0, 32'h0);
  endtask

  task automatic check_log(input int idx, input logic [31:0] ins, input logic [31:0] pc,
                           input logic c);
    if (log_q.size() <= idx) begin
      check("log_missing", log_q.size(), idx + 1);
    end else begin
      check("log_instr", log_q[idx].instr, ins);
      check("log_pc", log_q[idx].pc, pc);
      check("log_compr", {31'b0, log_q[idx].compr}, {31'b0, c});
    end
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h = 16'($urandom());
    if ($urandom_range(1) == 0) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

`ifdef FETCH_ALIGN_PERF_EN
  logic [31:0] pc0, pf0;
`endif

  initial begin
    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", {31'b0, o_instr_valid}, 32'd0);
    check("rst_ready", {31'b0, o_fetch_ready}, 32'd1);
    check("rst_pc", o_instr_pc, 32'h0);
    i_rst_n = 1'b1;
    i_instr_ready = 1'b1;

    // Two compressed then one 32-bit instruction.
    log_q.delete();
    push_word(32'h0001_0001, 1'b1);
    push_word(32'h00A0_0513, 1'b1);
    idle(4, 1'b1);
    check("mix_count", log_q.size(), 3);
    check_log(0, 32'h0000_0001, 32'h0, 1'b1);
    check_log(1, 32'h0000_0001, 32'h2, 1'b1);
    check_log(2, 32'h00A0_0513, 32'h4, 1'b0);

    // Straddling 32-bit instruction.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
`ifdef FETCH_ALIGN_PERF_EN
    pc0 = o_perf_compr_cnt; pf0 = o_perf_full_cnt;
`endif
    log_q.delete();
    push_word(32'h0513_4501, 1'b1);
    push_word(32'h0001_00A0, 1'b1);
    idle(4, 1'b1);
    check("strad_count", log_q.size(), 3);
    check_log(0, 32'h0000_4501, 32'h0, 1'b1);
    check_log(1, 32'h00A0_0513, 32'h2, 1'b0);
    check_log(2, 32'h0000_0001, 32'h6, 1'b1);
`ifdef FETCH_ALIGN_PERF_EN
    check("perf_strad_compr", o_perf_compr_cnt - pc0, 32'd2);
    check("perf_strad_full", o_perf_full_cnt - pf0, 32'd1);
    pc0 = o_perf_compr_cnt; pf0 = o_perf_full_cnt;
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
    check("perf_flush_compr", o_perf_compr_cnt, pc0);
    check("perf_flush_full", o_perf_full_cnt, pf0);
`endif

    // Backpressure: consumer stalls for 5 cycles while fetch stays valid.
    repeat (5) drive(1'b1, 32'h1234_0002, 1'b0, 1'b0, 32'h0);
    @(negedge i_clk);
    check("bp_ready_low", {31'b0, o_fetch_ready}, 32'd0);
    @(posedge i_clk); #1;
    idle(6, 1'b1);

    // Flush a full queue to 0x102, then the new word's low half is dropped.
    repeat (2) drive(1'b1, 32'h0001_0001, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h9999_9999, 1'b1, 1'b1, 32'h0000_0102);
    log_q.delete();
    push_word(32'h4505_AAAA, 1'b1);
    idle(3, 1'b1);
    check("flush_count", log_q.size(), 1);
    check_log(0, 32'h0000_4505, 32'h102, 1'b1);

    // Flush together with an offered fetch word: the word is discarded.
    drive(1'b1, 32'h0001_0001, 1'b1, 1'b1, 32'h0000_0200);
    @(negedge i_clk);
    check("flush_push_valid", {31'b0, o_instr_valid}, 32'd0);
    check("flush_push_pc", o_instr_pc, 32'h200);
    @(posedge i_clk); #1;

    // Mid-stream reset returns to the reset state.
    push_word(32'h0513_4501, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, o_instr_valid}, 32'd0);
    check("mid_rst_pc", o_instr_pc, 32'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic fl = ($urandom_range(40) == 0);
      logic [31:0] fp = {$urandom_range(255), 1'b0, 1'($urandom())} << 1;
      drive($urandom_range(3) != 0, {rand_hw(), rand_hw()},
            $urandom_range(3) != 0, fl, fp);
    end
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
